// File: rtl/jump_seq_ctrl_pkg.sv
// jump_seq_ctrl_pkg: shared opcodes, FSM states, exception codes and immediate helpers
package jump_seq_ctrl_pkg;
   localparam logic [6:0] OPC_JAL  = 7'b1101111;
   localparam logic [6:0] OPC_JALR = 7'b1100111;

   typedef enum logic [2:0] {IDLE, CALC, WB, FETCH, TRAP} state_e;

   typedef enum logic [1:0] {
      EXC_NONE     = 2'b00,
      EXC_MISALIGN = 2'b01,
      EXC_TIMEOUT  = 2'b10
   } exc_cause_e;

   function automatic logic [31:0] imm_j(input logic [31:0] insn);
      return {{12{insn[31]}}, insn[19:12], insn[20], insn[30:21], 1'b0};
   endfunction

   function automatic logic [31:0] imm_i(input logic [31:0] insn);
      return {{20{insn[31]}}, insn[31:20]};
   endfunction

   function automatic logic is_jal(input logic [31:0] insn);
      return insn[6:0] == OPC_JAL;
   endfunction

   function automatic logic is_jalr(input logic [31:0] insn);
      return insn[6:0] == OPC_JALR && insn[14:12] == 3'b000;
   endfunction
endpackage

// File: rtl/jump_seq_ctrl_if.sv
// jump_seq_ctrl_if: instruction, writeback, fetch and exception signals of the jump sequencer
interface jump_seq_ctrl_if #(parameter int XLEN = 32);
   logic            insn_valid;
   logic            insn_ready;
   logic [31:0]     INSN;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] rs1_data;
   logic            rd_we;
   logic [4:0]      rd_addr;
   logic [XLEN-1:0] rd_wdata;
   logic            pc_we;
   logic [XLEN-1:0] pc_next;
   logic            addr_sel;
   logic            sub_sra;
   logic            mem_we;
   logic            fetch_req;
   logic [XLEN-1:0] fetch_addr;
   logic            fetch_ack;
   logic            illegal;
   logic            exc_valid;
   logic [1:0]      exc_cause;
   logic            exc_ack;
   logic            busy;

   modport master (
      output insn_valid, INSN, pc, rs1_data, fetch_ack, exc_ack,
      input  insn_ready, rd_we, rd_addr, rd_wdata, pc_we, pc_next, addr_sel, sub_sra,
             mem_we, fetch_req, fetch_addr, illegal, exc_valid, exc_cause, busy
   );

   modport slave (
      input  insn_valid, INSN, pc, rs1_data, fetch_ack, exc_ack,
      output insn_ready, rd_we, rd_addr, rd_wdata, pc_we, pc_next, addr_sel, sub_sra,
             mem_we, fetch_req, fetch_addr, illegal, exc_valid, exc_cause, busy
   );
endinterface

// File: rtl/jump_seq_ctrl_target_calc.sv
// jump_target_calc: JAL/JALR target and link computation with target alignment check
module jump_target_calc
   import jump_seq_ctrl_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int ALIGN_BITS = 2
) (
   input  logic [31:0]     insn_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] rs1_i,
   output logic [XLEN-1:0] target_o,
   output logic [XLEN-1:0] link_o,
   output logic [4:0]      rd_o,
   output logic            misaligned_o
);
   logic            jal;
   logic [XLEN-1:0] sum;

   always_comb begin
      jal          = is_jal(insn_i);
      sum          = jal ? pc_i + XLEN'($signed(imm_j(insn_i)))
                         : rs1_i + XLEN'($signed(imm_i(insn_i)));
      target_o     = jal ? sum : {sum[XLEN-1:1], 1'b0};
      link_o       = pc_i + XLEN'(4);
      rd_o         = insn_i[11:7];
      misaligned_o = |target_o[ALIGN_BITS-1:0];
   end
endmodule

// File: rtl/jump_seq_ctrl.sv
// jump_seq_ctrl: multi-cycle JAL/JALR sequencer (accept, calc, writeback, target fetch, trap)
module jump_seq_ctrl
   import jump_seq_ctrl_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int ALIGN_BITS = 2,
   parameter int FETCH_TMO  = 15
) (
   input logic          CLK,
   input logic          RST,
   jump_seq_ctrl_if.slave bus
);
   localparam int CW = $clog2(FETCH_TMO + 1);

   state_e          state_q, state_d;
   exc_cause_e      cause_q;
   logic [31:0]     insn_q;
   logic [XLEN-1:0] pc_q, rs1_q, target_q, link_q;
   logic [XLEN-1:0] calc_target, calc_link;
   logic [4:0]      rd_q, calc_rd;
   logic            calc_mis, illegal_q, accept, jump_word, tmo_hit;
   logic [CW-1:0]   tmo_q, tmo_d;

   assign accept    = state_q == IDLE && bus.insn_valid;
   assign jump_word = is_jal(bus.INSN) || is_jalr(bus.INSN);
   assign tmo_hit   = tmo_q == CW'(FETCH_TMO - 1);

   jump_target_calc #(.XLEN(XLEN), .ALIGN_BITS(ALIGN_BITS)) u_calc (
      .insn_i       (insn_q),
      .pc_i         (pc_q),
      .rs1_i        (rs1_q),
      .target_o     (calc_target),
      .link_o       (calc_link),
      .rd_o         (calc_rd),
      .misaligned_o (calc_mis)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // fetch_ack is tested before the timeout so an ack on the limit cycle wins
   always_comb begin
      state_d = state_q;
      tmo_d   = '0;
      unique case (state_q)
         IDLE:    state_d = accept && jump_word ? CALC : IDLE;
         CALC:    state_d = calc_mis ? TRAP : WB;
         WB:      state_d = FETCH;
         FETCH: begin
            if (bus.fetch_ack)  state_d = IDLE;
            else if (tmo_hit)   state_d = TRAP;
            else                tmo_d   = tmo_q + 1'b1;
         end
         TRAP:    state_d = bus.exc_ack ? IDLE : TRAP;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         insn_q    <= '0;
         pc_q      <= '0;
         rs1_q     <= '0;
         target_q  <= '0;
         link_q    <= '0;
         rd_q      <= '0;
         tmo_q     <= '0;
         illegal_q <= 1'b0;
         cause_q   <= EXC_NONE;
      end else begin
         tmo_q     <= tmo_d;
         illegal_q <= accept && !jump_word;
         if (accept) begin
            insn_q <= bus.INSN;
            pc_q   <= bus.pc;
            rs1_q  <= bus.rs1_data;
         end
         if (state_q == CALC) begin
            target_q <= calc_target;
            link_q   <= calc_link;
            rd_q     <= calc_rd;
         end
         if (state_d == TRAP && state_q != TRAP)
            cause_q <= state_q == FETCH ? EXC_TIMEOUT : EXC_MISALIGN;
      end
   end

   always_comb begin
      bus.insn_ready = state_q == IDLE;
      bus.busy       = state_q != IDLE;
      bus.rd_we      = state_q == WB && rd_q != 5'd0;
      bus.rd_addr    = rd_q;
      bus.rd_wdata   = link_q;
      bus.pc_we      = state_q == WB;
      bus.pc_next    = target_q;
      bus.addr_sel   = state_q == FETCH;
      bus.fetch_req  = state_q == FETCH;
      bus.fetch_addr = target_q;
      bus.sub_sra    = 1'b0;
      bus.mem_we     = 1'b0;
      bus.illegal    = illegal_q;
      bus.exc_valid  = state_q == TRAP;
      bus.exc_cause  = state_q == TRAP ? cause_q : EXC_NONE;
   end
endmodule

// File: tb/tb_jump_seq_ctrl.sv
// tb_jump_seq_ctrl: vector table, hand sequences and random jumps against a transaction-level model
module tb_jump_seq_ctrl;
   localparam int K_OK = 0, K_MIS = 1, K_TMO = 2, K_ILL = 3;

   typedef struct {
      logic [31:0] insn;
      logic [31:0] pc;
      logic [31:0] rs1;
      int          dly;
      int          kind;
      logic [31:0] tgt;
      logic [31:0] link;
   } vec_t;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   n_cmp = 0;
   int   n_fail = 0;

   jump_seq_ctrl_if #(.XLEN(32)) bus0 ();
   jump_seq_ctrl_if #(.XLEN(32)) bus1 ();

   jump_seq_ctrl #(.XLEN(32), .ALIGN_BITS(2), .FETCH_TMO(15)) dut0 (.CLK(CLK), .RST(RST), .bus(bus0));
   jump_seq_ctrl #(.XLEN(32), .ALIGN_BITS(1), .FETCH_TMO(15)) dut1 (.CLK(CLK), .RST(RST), .bus(bus1));

   assign bus1.insn_valid = bus0.insn_valid;
   assign bus1.INSN       = bus0.INSN;
   assign bus1.pc         = bus0.pc;
   assign bus1.rs1_data   = bus0.rs1_data;
   assign bus1.fetch_ack  = bus0.fetch_ack;
   assign bus1.exc_ack    = bus0.exc_ack;

   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Expected outcome computed straight from the jump semantics
   function automatic vec_t model(input logic [31:0] insn, pc, rs1, input int dly);
      vec_t v;
      logic signed [20:0] jb;
      logic signed [11:0] ib;
      int ij, ii;
      v.insn = insn; v.pc = pc; v.rs1 = rs1; v.dly = dly;
      v.link = pc + 32'd4;
      v.tgt  = 32'd0;
      jb = {insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
      ib = insn[31:20];
      ij = jb;
      ii = ib;
      if (insn[6:0] == 7'h6F) v.tgt = pc + ij;
      else if (insn[6:0] == 7'h67 && insn[14:12] == 3'd0) v.tgt = (rs1 + ii) & ~32'd1;
      else begin
         v.kind = K_ILL;
         return v;
      end
      v.kind = (v.tgt % 4 != 0) ? K_MIS : (dly >= 15 ? K_TMO : K_OK);
      return v;
   endfunction

   task automatic run_txn(input vec_t v);
      int w = 0, c, n_pcwe = 0, n_rdwe = 0, n_ill = 0, n_req = 0, n_exc = 0;
      int pcwe_c = 0, req_c = 0, exc_c = 0, bad_fa = 0, bad_cause = 0, rdwe_c = 0;
      logic [31:0] pcn = 0, rdd = 0;
      logic [4:0]  rda = 0;
      logic [1:0]  cause = 0;
      logic done = 1'b0;
      logic wr = v.kind == K_OK || v.kind == K_TMO;
      while (!bus0.insn_ready && w < 50) begin tick(); w++; end
      chk("ready_before_accept", bus0.insn_ready, 1);
      bus0.INSN = v.insn; bus0.pc = v.pc; bus0.rs1_data = v.rs1; bus0.insn_valid = 1'b1;
      tick();
      bus0.insn_valid = 1'b0;
      for (c = 1; c <= 60 && !done; c++) begin
         if (bus0.pc_we) begin n_pcwe++; pcwe_c = c; pcn = bus0.pc_next; end
         if (bus0.rd_we) begin n_rdwe++; rdwe_c = c; rda = bus0.rd_addr; rdd = bus0.rd_wdata; end
         if (bus0.illegal) n_ill++;
         if (bus0.fetch_req) begin
            n_req++;
            if (req_c == 0) req_c = c;
            if (bus0.fetch_addr !== v.tgt || !bus0.addr_sel) bad_fa++;
         end
         if (bus0.exc_valid) begin
            n_exc++;
            if (exc_c == 0) begin exc_c = c; cause = bus0.exc_cause; end
            else if (bus0.exc_cause !== cause) bad_cause++;
         end
         if (!bus0.busy && c >= 2) done = 1'b1;
         else begin
            bus0.fetch_ack = bus0.fetch_req && n_req == v.dly + 1;
            bus0.exc_ack   = bus0.exc_valid && n_exc == 3;
            tick();
         end
      end
      bus0.fetch_ack = 1'b0;
      bus0.exc_ack   = 1'b0;
      chk("txn_completed", done, 1);
      chk("illegal_pulses", n_ill, v.kind == K_ILL ? 1 : 0);
      chk("pc_we_pulses", n_pcwe, wr ? 1 : 0);
      chk("rd_we_pulses", n_rdwe, wr && v.insn[11:7] != 5'd0 ? 1 : 0);
      chk("fetch_req_cycles", n_req, v.kind == K_OK ? v.dly + 1 : v.kind == K_TMO ? 15 : 0);
      chk("exc_cycles", n_exc, v.kind == K_MIS || v.kind == K_TMO ? 3 : 0);
      if (n_pcwe != 0) begin
         chk("pc_we_cycle", pcwe_c, 2);
         chk("pc_next", pcn, v.tgt);
      end
      if (n_rdwe != 0) begin
         chk("rd_we_cycle", rdwe_c, 2);
         chk("rd_addr", rda, v.insn[11:7]);
         chk("rd_wdata", rdd, v.link);
      end
      if (n_req != 0) begin
         chk("fetch_first_cycle", req_c, 3);
         chk("fetch_addr_stable", bad_fa, 0);
      end
      if (n_exc != 0) begin
         chk("exc_first_cycle", exc_c, v.kind == K_MIS ? 2 : 18);
         chk("exc_cause", cause, v.kind == K_MIS ? 2'b01 : 2'b10);
         chk("exc_cause_stable", bad_cause, 0);
      end
   endtask

   vec_t tbl[9];

   initial begin
      tbl[0] = '{32'h008000EF, 32'h00000100, 32'h0,      0,  K_OK,  32'h00000108, 32'h00000104};
      tbl[1] = '{32'h00328067, 32'h00000100, 32'h200,    0,  K_MIS, 32'h00000202, 32'h00000104};
      tbl[2] = '{32'h008000EF, 32'h00000100, 32'h0,      99, K_TMO, 32'h00000108, 32'h00000104};
      tbl[3] = '{32'h008000EF, 32'h00000100, 32'h0,      14, K_OK,  32'h00000108, 32'h00000104};
      tbl[4] = '{32'h00000013, 32'h00000100, 32'h0,      0,  K_ILL, 32'h0,        32'h0};
      tbl[5] = '{32'h008000EF, 32'hFFFFFFFC, 32'h0,      2,  K_OK,  32'h00000004, 32'h00000000};
      tbl[6] = '{32'h004100E7, 32'h00000040, 32'h1000,   3,  K_OK,  32'h00001004, 32'h00000044};
      tbl[7] = '{32'h004110E7, 32'h00000040, 32'h1000,   0,  K_ILL, 32'h0,        32'h0};
      tbl[8] = '{32'hFFDFF2EF, 32'h00000200, 32'h0,      1,  K_OK,  32'h000001FC, 32'h00000204};

      bus0.insn_valid = 1'b0; bus0.INSN = '0; bus0.pc = '0; bus0.rs1_data = '0;
      bus0.fetch_ack = 1'b0; bus0.exc_ack = 1'b0;
      repeat (3) tick();
      RST = 1'b0;
      tick();
      chk("rst_insn_ready", bus0.insn_ready, 1);
      chk("rst_busy", bus0.busy, 0);
      chk("rst_strobes", {bus0.rd_we, bus0.pc_we, bus0.fetch_req, bus0.illegal, bus0.exc_valid}, 0);
      chk("rst_pc_next", bus0.pc_next, 0);
      chk("rst_const", {bus0.sub_sra, bus0.mem_we, bus0.addr_sel}, 0);

      // Same misaligned-for-4 JALR on both instances: ALIGN_BITS=1 jumps, ALIGN_BITS=2 traps
      bus0.INSN = 32'h00328067; bus0.pc = 32'h100; bus0.rs1_data = 32'h200; bus0.insn_valid = 1'b1;
      tick();
      bus0.insn_valid = 1'b0;
      tick();
      chk("a1_pc_we", bus1.pc_we, 1);
      chk("a1_pc_next", bus1.pc_next, 32'h202);
      chk("a1_rd_we_x0", bus1.rd_we, 0);
      chk("a2_exc", {bus0.exc_valid, bus0.exc_cause, bus0.pc_we}, 4'b1010);
      tick();
      chk("a1_fetch", {bus1.fetch_req, bus1.addr_sel}, 2'b11);
      chk("a1_fetch_addr", bus1.fetch_addr, 32'h202);
      bus0.fetch_ack = 1'b1; bus0.exc_ack = 1'b1;
      tick();
      bus0.fetch_ack = 1'b0; bus0.exc_ack = 1'b0;
      chk("a1_idle", {bus1.insn_ready, bus1.exc_valid}, 2'b10);
      chk("a2_idle", {bus0.insn_ready, bus0.exc_valid}, 2'b10);

      for (int i = 0; i < 9; i++) run_txn(tbl[i]);

      // Reset in FETCH aborts immediately
      begin
         int w = 0;
         bus0.INSN = 32'h008000EF; bus0.pc = 32'h100; bus0.insn_valid = 1'b1;
         tick();
         bus0.insn_valid = 1'b0;
         while (!bus0.fetch_req && w < 10) begin tick(); w++; end
         chk("pre_rst_fetch", bus0.fetch_req, 1);
         RST = 1'b1;
         #1;
         chk("rst_mid_strobes", {bus0.rd_we, bus0.pc_we, bus0.fetch_req, bus0.exc_valid, bus0.busy, bus0.addr_sel}, 0);
         chk("rst_mid_addr", bus0.fetch_addr, 0);
         repeat (2) tick();
         RST = 1'b0;
         tick();
         run_txn(tbl[0]);
      end

      for (int i = 0; i < 40; i++) begin
         logic [31:0] insn, pc, rs1;
         int k = $urandom_range(0, 3);
         pc  = $urandom & ~32'd3;
         rs1 = $urandom;
         insn = $urandom;
         if (k == 0) insn = (insn & 32'hFFFFF000) | ($urandom_range(0, 31) << 7) | 32'h6F;
         if (k == 1) insn = (insn & 32'hFFF00000) | ($urandom_range(0, 31) << 15) | ($urandom_range(0, 31) << 7) | 32'h67;
         if (k == 2) begin
            insn = (insn & 32'hFFC00000) | ($urandom_range(0, 31) << 7) | 32'h67;
            rs1  = rs1 & ~32'd3;
         end
         run_txn(model(insn, pc, rs1, $urandom_range(0, 16)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/jump_seq_ctrl.md
Name: jump_seq_ctrl

Overview:
Multi-cycle control sequencer for RISC-V jump instructions (JAL, JALR).
- Accepts an instruction over a valid/ready handshake and extracts the J/I immediates.
- Computes the jump target and link value, checks target alignment, and commits rd and PC writes.
- Drives the target fetch over a req/ack handshake with timeout, raising an exception on misalignment or fetch timeout.
- Sits in the control unit alongside the per-type instruction decoders and replaces the purely clock-phased J-type decode path.

Parameters:
XLEN, 32, datapath/address width (≥ 32)
ALIGN_BITS, 2, low target bits that must be zero (2 = 4-byte, 1 = compressed-capable)
FETCH_TMO, 15, max cycles in FETCH without fetch_ack before trap (≥ 1)

Ports:
CLK  in  1  processor clock, rising edge
RST  in  1  reset, asynchronous, active-high
insn_valid  in  1  INSN presented
insn_ready  out  1  sequencer can accept (IDLE only)
INSN  in  32  instruction word
pc  in  XLEN  PC of INSN
rs1_data  in  XLEN  rs1 register value (for JALR)
rd_we  out  1  register-file write strobe
rd_addr  out  5  destination register
rd_wdata  out  XLEN  link value pc+4
pc_we  out  1  PC write strobe
pc_next  out  XLEN  new PC
addr_sel  out  1  memory address = fetch_addr (1) / PC (0)
sub_sra  out  1  ALU add/sub select, constant 0
mem_we  out  1  memory write, constant 0
fetch_req  out  1  fetch request
fetch_addr  out  XLEN  fetch address
fetch_ack  in  1  fetch accepted
illegal  out  1  one-cycle pulse: accepted word is not JAL/JALR
exc_valid  out  1  exception pending
exc_cause  out  2  01 misaligned target, 10 fetch timeout
exc_ack  in  1  exception consumed
busy  out  1  state != IDLE

Behaviour:
- Reset (async): state IDLE; all registered outputs 0; timeout counter 0. Reset mid-operation aborts with no write or fetch.
- Decode:
  - JAL = opcode 1101111.
  - JALR = opcode 1100111 and funct3 000.
  - Immediates are sign-extended to XLEN.
- IDLE: insn_ready=1; handshake on insn_valid & insn_ready.
  - JAL/JALR accepted → CALC.
  - Any other word → illegal=1 next cycle; remain IDLE.
- CALC, one cycle:
  - JAL target = pc + immJ.
  - JALR target = (rs1_data + immI) with bit0 cleared.
  - Link = pc + 4. All additions are mod 2^XLEN, wrap silently.
  - Register target, link, rd, and misaligned = |target[ALIGN_BITS-1:0].
- Next state: misaligned → TRAP, cause 01, with no rd/pc write; else → WB.
- WB, one cycle:
  - pc_we=1, pc_next=target.
  - rd_we=1 only if rd≠0; rd_wdata=link.
  - → FETCH.
- FETCH:
  - fetch_req=1, fetch_addr=target, addr_sel=1; held stable until fetch_ack.
  - fetch_ack → IDLE; counter cleared.
  - Counter increments each FETCH cycle without ack. On reaching FETCH_TMO → TRAP, cause 10, fetch_req dropped.
  - Ack in the same cycle the limit is hit: ack wins.
- TRAP: exc_valid=1 and exc_cause stable until exc_ack; then → IDLE with exc_valid cleared next cycle. exc_ack outside TRAP is ignored.
- Latency: accept edge N; CALC N+1; WB/TRAP N+2; fetch_req first high N+3. Next insn_ready no earlier than the cycle after fetch_ack.
- Strobes rd_we, pc_we, and illegal are exactly one cycle wide.
- insn_valid while busy is ignored, and INSN is not captured.

Decomposition:
- Shared control package holds:
  - opcode constants OPC_JAL, OPC_JALR
  - state enum IDLE, CALC, WB, FETCH, TRAP
  - exc_cause codes
  - immediate-extract functions imm_j, imm_i
- One sub-module: jump_target_calc (combinational immediate select, adder, bit0 clear, alignment check).
- FSM, counter, and output registers stay in jump_seq_ctrl.

Test Plan:
- JAL 0x008000EF, pc=0x100, fetch_ack at first request → pc_next=0x108, rd_addr=1, rd_wdata=0x104, rd_we and pc_we one cycle at N+2, fetch_addr=0x108 at N+3.
- JALR 0x00328067, rs1_data=0x200, ALIGN_BITS=2 → exc_valid, cause 01; no rd_we/pc_we/fetch_req; exc_ack → IDLE.
- Same JALR, ALIGN_BITS=1 → pc_next=0x202, rd_we stays 0 (rd=x0), fetch_addr=0x202.
- JAL 0x008000EF, fetch_ack held 0 → fetch_req high exactly 15 cycles, then exc_cause 10. Second run with ack on the 15th cycle → IDLE, no trap.
- INSN=0x00000013 (addi) → illegal one-cycle pulse, insn_ready stays 1, no other strobe.
- Assert RST during FETCH → all outputs 0 immediately; after release, a new JAL is accepted normally. JAL with pc=0xFFFFFFFC → link wraps to 0x00000000.
